// File: rtl/isp_blc_stat_pkg.sv
// Shared ISP definitions: Bayer channel encodings, black-level FSM state codes
// and the 8-bit saturation helper used by the BLC blocks.
package isp_blc_stat_pkg;

   typedef enum logic [1:0] {
      BAYER_GB = 2'b00,
      BAYER_B  = 2'b01,
      BAYER_R  = 2'b10,
      BAYER_GR = 2'b11
   } bayer_ch_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_CALC  = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   function automatic logic [7:0] sat8(input logic [31:0] value);
      logic [7:0] result;
      if (value > 32'd255) begin
         result = 8'hFF;
      end else begin
         result = value[7:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/isp_bayer_cnt.sv
// Raster position counters for an enabled pixel stream, plus the Bayer channel
// of the pixel at the current position.
module isp_bayer_cnt
   import isp_blc_stat_pkg::*;
#(
   parameter int WIDTH  = 1936,
   parameter int HEIGHT = 1088,
   parameter int HW     = $clog2(WIDTH),
   parameter int VW     = $clog2(HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output bayer_ch_e     chan
);

   localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
   localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);

   logic [HW-1:0] h_cnt_r;
   logic [VW-1:0] v_cnt_r;

   // Raster counters: advance on each enabled pixel, wrap at line and frame ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt_r <= '0;
         v_cnt_r <= '0;
      end else if (en) begin
         if (h_cnt_r == H_LAST) begin
            h_cnt_r <= '0;
            if (v_cnt_r == V_LAST) begin
               v_cnt_r <= '0;
            end else begin
               v_cnt_r <= v_cnt_r + VW'(1);
            end
         end else begin
            h_cnt_r <= h_cnt_r + HW'(1);
            v_cnt_r <= v_cnt_r;
         end
      end else begin
         h_cnt_r <= h_cnt_r;
         v_cnt_r <= v_cnt_r;
      end
   end

   assign h_cnt = h_cnt_r;
   assign v_cnt = v_cnt_r;
   assign chan  = bayer_ch_e'({v_cnt_r[0], h_cnt_r[0]});

endmodule

// File: rtl/isp_blc_stat.sv
// Optical-black statistics: averages each Bayer channel over the top-left OB
// window once per frame and presents the rounded, saturated black levels.
module isp_blc_stat
   import isp_blc_stat_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int WIDTH     = 1936,
   parameter int HEIGHT    = 1088,
   parameter int OB_ROWS   = 8,
   parameter int OB_COLS   = 64,
   parameter int DEF_BLACK = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [BITS-1:0] per_raw_data,
   input  logic            per_raw_data_en,
   input  logic            freeze,
   output logic [7:0]      black_gb,
   output logic [7:0]      black_b,
   output logic [7:0]      black_r,
   output logic [7:0]      black_gr,
   output logic            black_valid
);

   localparam int N     = (OB_ROWS / 2) * (OB_COLS / 2);
   localparam int LOG2N = $clog2(N);
   localparam int AW    = BITS + LOG2N;
   localparam int HW    = $clog2(WIDTH);
   localparam int VW    = $clog2(HEIGHT);

   localparam logic [VW-1:0] OBR_LAST = VW'(OB_ROWS - 1);
   localparam logic [HW-1:0] OBC_LAST = HW'(OB_COLS - 1);
   localparam logic [AW-1:0] HALF_N   = AW'(N / 2);
   localparam logic [7:0]    DEF_B8   = 8'(DEF_BLACK);

   logic [BITS-1:0] pix_r;
   logic            pix_en_r;
   logic [HW-1:0]   h_cnt_s;
   logic [VW-1:0]   v_cnt_s;
   bayer_ch_e       chan_s;
   logic [1:0]      state_r;
   logic [1:0]      state_nx_s;
   logic            at_first_s;
   logic            at_last_s;
   logic            in_win_s;
   logic            acc_en_s;
   logic [AW-1:0]   acc_r [4];
   logic [7:0]      res_s [4];
   logic [7:0]      black_gb_r;
   logic [7:0]      black_b_r;
   logic [7:0]      black_r_r;
   logic [7:0]      black_gr_r;
   logic            black_valid_r;

   // Input stage: the counters describe the pixel held in pix_r.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_r    <= '0;
         pix_en_r <= 1'b0;
      end else begin
         pix_r    <= per_raw_data;
         pix_en_r <= per_raw_data_en;
      end
   end

   isp_bayer_cnt #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .HW     (HW),
      .VW     (VW)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en_r),
      .h_cnt (h_cnt_s),
      .v_cnt (v_cnt_s),
      .chan  (chan_s)
   );

   assign at_first_s = pix_en_r && (h_cnt_s == '0) && (v_cnt_s == '0);
   assign at_last_s  = pix_en_r && (h_cnt_s == OBC_LAST) && (v_cnt_s == OBR_LAST);
   assign in_win_s   = pix_en_r && (h_cnt_s <= OBC_LAST) && (v_cnt_s <= OBR_LAST);

   // Next-state logic; CALC lasts exactly one cycle whatever the enable does.
   always_comb begin
      state_nx_s = state_r;
      acc_en_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_WAIT: begin
            if (at_first_s) begin
               state_nx_s = ST_ACCUM;
               acc_en_s   = in_win_s;
            end else begin
               state_nx_s = state_r;
               acc_en_s   = 1'b0;
            end
         end
         ST_ACCUM: begin
            acc_en_s = in_win_s;
            if (at_last_s) begin
               state_nx_s = ST_CALC;
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_CALC: begin
            state_nx_s = ST_WAIT;
            acc_en_s   = 1'b0;
         end
         default: begin
            state_nx_s = ST_IDLE;
            acc_en_s   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Per-channel accumulators, emptied as CALC hands off to WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            acc_r[i] <= '0;
         end
      end else if (state_r == ST_CALC) begin
         for (int i = 0; i < 4; i++) begin
            acc_r[i] <= '0;
         end
      end else if (acc_en_s) begin
         acc_r[chan_s] <= acc_r[chan_s] + AW'(pix_r);
      end else begin
         for (int i = 0; i < 4; i++) begin
            acc_r[i] <= acc_r[i];
         end
      end
   end

   // Round-half-up mean; acc + N/2 stays below 2**AW so no carry is lost.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         res_s[i] = sat8(32'((acc_r[i] + HALF_N) >> LOG2N));
      end
   end

   // Output registers: loaded once per window unless frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         black_gb_r    <= DEF_B8;
         black_b_r     <= DEF_B8;
         black_r_r     <= DEF_B8;
         black_gr_r    <= DEF_B8;
         black_valid_r <= 1'b0;
      end else if ((state_r == ST_CALC) && !freeze) begin
         black_gb_r    <= res_s[BAYER_GB];
         black_b_r     <= res_s[BAYER_B];
         black_r_r     <= res_s[BAYER_R];
         black_gr_r    <= res_s[BAYER_GR];
         black_valid_r <= 1'b1;
      end else begin
         black_gb_r    <= black_gb_r;
         black_b_r     <= black_b_r;
         black_r_r     <= black_r_r;
         black_gr_r    <= black_gr_r;
         black_valid_r <= 1'b0;
      end
   end

   assign black_gb    = black_gb_r;
   assign black_b     = black_b_r;
   assign black_r     = black_r_r;
   assign black_gr    = black_gr_r;
   assign black_valid = black_valid_r;

endmodule

// File: doc/isp_blc_stat.md
ISP_BLC_STAT -- requirements
Module: isp_blc_stat

Interface
REQ-001 Parameter BITS, default 8, raw pixel width.
REQ-002 Parameter WIDTH, default 1936, active pixels per line.
REQ-003 Parameter HEIGHT, default 1088, lines per frame.
REQ-004 Parameter OB_ROWS, default 8, optical-black window height (top rows); power of two, at least 2.
REQ-005 Parameter OB_COLS, default 64, optical-black window width (leftmost columns); power of two, at least 2, no larger than WIDTH.
REQ-006 Parameter DEF_BLACK, default 16, 8-bit black level presented after reset.
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 per_raw_data  input  BITS  raw Bayer pixel.
REQ-010 per_raw_data_en  input  1  pixel qualifier; one pixel per cycle while high.
REQ-011 freeze  input  1  when high, the end-of-window result is discarded and outputs hold.
REQ-012 black_gb, black_b, black_r, black_gr  output  8 each  measured black levels, registered; they feed the BLC black inputs directly.
REQ-013 black_valid  output  1  one-cycle pulse when the black_* outputs take new values.

Function
REQ-014 Internal h_cnt/v_cnt shall advance only on per_raw_data_en: h_cnt wraps WIDTH-1 to 0; v_cnt increments on the h wrap and wraps HEIGHT-1 to 0.
REQ-015 Channel select shall be {v_cnt[0],h_cnt[0]}: 00 gb, 01 b, 10 r, 11 gr.
REQ-016 A sample shall be in the window when per_raw_data_en=1, v_cnt<OB_ROWS and h_cnt<OB_COLS.
REQ-017 Each window sample shall be added to its channel accumulator.
REQ-018 Each accumulator shall be BITS+log2(N) bits wide, where N=(OB_ROWS/2)*(OB_COLS/2) samples per channel; accumulators never overflow.
REQ-019 The FSM shall have states IDLE, ACCUM, CALC and WAIT.
REQ-020 IDLE to ACCUM: on an enabled sample at (0,0); that sample is accumulated.
REQ-021 ACCUM to CALC: on the enabled sample at (OB_ROWS-1, OB_COLS-1); that sample is accumulated.
REQ-022 CALC to WAIT: unconditional after one cycle.
REQ-023 WAIT to ACCUM: on an enabled sample at (0,0).
REQ-024 In CALC, each result shall be (acc + N/2) >> log2(N), i.e. round half up, then saturated to 255.
REQ-025 In CALC with freeze=0, black_* shall be registered with the results and black_valid=1 for exactly that one cycle.
REQ-026 In CALC with freeze=1, black_* shall hold and black_valid shall stay 0.
REQ-027 On leaving CALC, all accumulators shall clear regardless of freeze.
REQ-028 Latency: black_* and black_valid shall change at the second rising edge after the edge that samples the last window pixel.
REQ-029 per_raw_data_en low shall hold the counters, accumulators and FSM state (except CALC, which always completes).
REQ-030 A window sample coinciding with CALC is impossible by geometry; no stall path is required.
REQ-031 Between updates, black_* shall remain stable.

Reset
REQ-032 rst_n=0 at a clock edge shall set h_cnt, v_cnt and all accumulators to 0 and the FSM to IDLE.
REQ-033 rst_n=0 at a clock edge shall set black_* to DEF_BLACK and black_valid to 0.
REQ-034 Reset mid-window shall discard the partial sums; the next enabled sample is treated as (0,0).

Structure
REQ-035 Bayer channel encodings (GB=00, B=01, R=10, GR=11) shall live in the shared ISP header and be used by isp_blc and isp_blc_stat.
REQ-036 One sub-module, isp_bayer_cnt (h/v counters plus channel select), shall be instantiated once; accumulators, FSM and divide stay in the top level.

Verification
REQ-037 Flat frame, all pixels 16 -> black_valid once per frame; all four outputs = 16.
REQ-038 Per-channel window values gb=10, b=20, r=30, gr=40 (pixels outside the window = 200) -> outputs 10/20/30/40.
REQ-039 Gb samples half 4 and half 5, other channels 0 -> black_gb = 5 (round half up), other outputs 0.
REQ-040 BITS=10, all window pixels 1023 -> all outputs 255 (saturated).
REQ-041 freeze=1 at the end of frame 2 after frame 1 produced 12 -> no pulse in frame 2; outputs stay 12; frame 3 with freeze=0 updates to the new values.
REQ-042 Random per_raw_data_en gaps, plus reset asserted at window row 3 -> results equal the gap-free case; after reset, outputs = DEF_BLACK until the next full window completes.
